// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped, write-through data cache:
// cache geometry, address field widths and positions, the controller state
// encoding and the default main-memory read latency.
// No ports (package).
// ----------------------------------------------------------------------------
package dcache_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int SETS    = 32;
  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;

  // Byte address layout: [15:9] tag, [8:4] index, [3:1] word, [0] ignored
  localparam int TAG_W   = 7;
  localparam int IDX_W   = 5;
  localparam int OFF_W   = 3;
  localparam int IDX_LSB = OFF_W + 1;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Number of cycles the pipeline is frozen by one read miss: the miss
  // cycle, the eight issue cycles, and the tail of the memory latency.
  function automatic int fill_stall_cycles();
    return WORDS + MEM_LAT + 1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// ----------------------------------------------------------------------------
// dcache_array
// Storage for the cache: per-line data words, tags and valid bits.
// Reads are combinational; all writes land at the clock edge, so a same-cycle
// read of a word being written still returns the old value.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset (valid only)
//   rd_idx_i, rd_word_i    read address (line index, word in line)
//   rd_data_o              data word at rd_idx_i/rd_word_i
//   rd_tag_o, rd_valid_o   tag and valid bit of line rd_idx_i
//   wr_en_i                write one data word
//   wr_idx_i, wr_word_i    word write address
//   wr_data_i              word write data
//   tag_we_i               install tag and mark line valid
//   tag_idx_i, tag_i       line to install and its tag
// ----------------------------------------------------------------------------
module dcache_array
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [OFF_W-1:0]  rd_word_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_W-1:0]  wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              tag_we_i,
  input  logic [IDX_W-1:0]  tag_idx_i,
  input  logic [TAG_W-1:0]  tag_i
);

  logic [DATA_W-1:0] data_q [SETS][WORDS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;

  // Data words are never reset; only the valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_word_i] <= wr_data_i;
    end
  end

  // Tags are likewise left alone on reset.
  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_q[tag_idx_i] <= tag_i;
    end
  end

  // Reset wins over a line being installed in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[tag_idx_i] <= 1'b1;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i][rd_word_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller that
// sits between the MEM stage and a pipelined multi-cycle main memory.
// Load hits return data in the same cycle; a load miss stalls the pipeline
// and fills the whole line with eight back-to-back reads. Stores always go
// straight to memory in one cycle and update the line only if it is present.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cpu_en       request valid (load or store)
//   cpu_wr       1 = store, 0 = load
//   cpu_addr     byte address, bit 0 ignored
//   cpu_wdata    store data
//   cpu_rdata    load data (valid on a non-stalled load)
//   cpu_stall    freeze the pipeline
//   mem_req      memory request valid
//   mem_we       1 = write, 0 = read
//   mem_addr     word-aligned byte address
//   mem_wdata    write data
//   mem_rdata    read return data
//   mem_rvalid   read return strobe, one per read, in issue order
// ----------------------------------------------------------------------------
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam logic [OFF_W:0]   BEATS     = OFF_W'(WORDS - 1) + {{OFF_W{1'b0}}, 1'b1};
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  state_e                   state_q, state_d;
  logic [OFF_W:0]           issue_cnt_q, issue_cnt_d;
  logic [OFF_W-1:0]         ret_cnt_q, ret_cnt_d;
  logic [TAG_W+IDX_W-1:0]   fill_line_q, fill_line_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_word;
  logic              unused_addr_lsb;
  logic              hit;

  logic [DATA_W-1:0] arr_rd_data;
  logic [TAG_W-1:0]  arr_rd_tag;
  logic              arr_rd_valid;
  logic              arr_wr_en;
  logic [IDX_W-1:0]  arr_wr_idx;
  logic [OFF_W-1:0]  arr_wr_word;
  logic [DATA_W-1:0] arr_wr_data;
  logic              arr_tag_we;

  assign req_tag         = cpu_addr[ADDR_W-1:TAG_LSB];
  assign req_idx         = cpu_addr[TAG_LSB-1:IDX_LSB];
  assign req_word        = cpu_addr[IDX_LSB-1:1];
  assign unused_addr_lsb = cpu_addr[0];

  assign hit = cpu_en & arr_rd_valid & (arr_rd_tag == req_tag);

  dcache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (req_idx),
    .rd_word_i  (req_word),
    .rd_data_o  (arr_rd_data),
    .rd_tag_o   (arr_rd_tag),
    .rd_valid_o (arr_rd_valid),
    .wr_en_i    (arr_wr_en),
    .wr_idx_i   (arr_wr_idx),
    .wr_word_i  (arr_wr_word),
    .wr_data_i  (arr_wr_data),
    .tag_we_i   (arr_tag_we),
    .tag_idx_i  (fill_line_q[IDX_W-1:0]),
    .tag_i      (fill_line_q[TAG_W+IDX_W-1:IDX_W])
  );

  // The single array write port is shared: fill returns own it during FILL,
  // store hits own it during IDLE. A return arriving in IDLE is a leftover
  // from an aborted fill and must never be written. Nothing is written while
  // reset is asserted so an aborted fill leaves no trace.
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_idx  = req_idx;
    arr_wr_word = req_word;
    arr_wr_data = cpu_wdata;
    arr_tag_we  = 1'b0;
    if (!rst) begin
      if (state_q == FILL) begin
        arr_wr_en   = mem_rvalid;
        arr_wr_idx  = fill_line_q[IDX_W-1:0];
        arr_wr_word = ret_cnt_q;
        arr_wr_data = mem_rdata;
        arr_tag_we  = mem_rvalid & (ret_cnt_q == LAST_BEAT);
      end else begin
        arr_wr_en = cpu_en & cpu_wr & hit;
      end
    end
  end

  // State, counters and the line being filled. Reset aborts any fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      fill_line_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      fill_line_q <= fill_line_d;
    end
  end

  // Issue and return progress are tracked separately because memory is
  // pipelined: all eight reads go out before the first one comes back. The
  // fill ends on the last return, not on a fixed cycle count.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    fill_line_d = fill_line_q;
    unique case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (cpu_en && !cpu_wr && !hit) begin
          state_d     = FILL;
          fill_line_d = {req_tag, req_idx};
        end
      end
      FILL: begin
        if (issue_cnt_q < BEATS) begin
          issue_cnt_d = issue_cnt_q + {{OFF_W{1'b0}}, 1'b1};
        end
        if (mem_rvalid) begin
          ret_cnt_d = ret_cnt_q + {{(OFF_W-1){1'b0}}, 1'b1};
          if (ret_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to zero while reset is asserted. In IDLE a store is
  // forwarded to memory in the same cycle whether or not it hits; a load
  // either returns data or raises stall. During FILL the stall is held and
  // one read per cycle is issued until all eight beats are out.
  always_comb begin
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_en) begin
            if (cpu_wr) begin
              mem_req   = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = {cpu_addr[ADDR_W-1:1], 1'b0};
              mem_wdata = cpu_wdata;
            end else if (hit) begin
              cpu_rdata = arr_rd_data;
            end else begin
              cpu_stall = 1'b1;
            end
          end
        end
        FILL: begin
          cpu_stall = 1'b1;
          if (issue_cnt_q < BEATS) begin
            mem_req  = 1'b1;
            mem_addr = {fill_line_q, issue_cnt_q[OFF_W-1:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. It answers the pipeline's MEM-stage data memory requests and replaces the single-cycle data memory. Hits complete in the same cycle. A read miss asserts stall and runs a block-fill FSM against a multi-cycle, pipelined main memory. The block is the responder side of the CPU data-memory interface (enable/wr/addr/data_in/data_out) and the initiator toward main memory.

Parameters:
SETS, 32, number of cache lines (index width = log2(SETS) = 5)
WORDS, 8, 16-bit words per line (16-byte line, offset width 3)
MEM_LAT, 4, cycles from mem_req (read) to mem_rvalid

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_en  in  1  request valid (the pipeline's MemRead|MemWrite)
cpu_wr  in  1  1 = store, 0 = load
cpu_addr  in  16  byte address; bit 0 ignored
cpu_wdata  in  16  store data
cpu_rdata  out  16  load data, valid when cpu_en & ~cpu_wr & ~cpu_stall
cpu_stall  out  1  freeze pipeline; CPU holds all cpu_* stable while high
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  16  word-aligned byte address
mem_wdata  out  16  write data
mem_rdata  in  16  read return data
mem_rvalid  in  1  mem_rdata valid; one pulse per read, in issue order

Behaviour:
- Address split: tag = addr[15:9], index = addr[8:4], word = addr[3:1].
- hit = cpu_en & valid[index] & (tag_arr[index] == tag). Evaluated combinationally.
- Reset (synchronous, rst=1 at clock edge):
  - All valid bits cleared; data and tag arrays are not cleared.
  - State = IDLE; issue and return counters = 0.
  - All outputs 0: cpu_rdata=0, cpu_stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, FILL.
- IDLE, load hit:
  - cpu_rdata = data_arr[index][word] combinationally (same-cycle, like the old single-cycle memory).
  - cpu_stall = 0.
- IDLE, load miss:
  - cpu_stall = 1 combinationally in the same cycle T.
  - Next state = FILL. Latch fill_base = {tag, index, 4'b0}.
- FILL issue:
  - Cycle T+1+k, k = 0..7: mem_req=1, mem_we=0, mem_addr = fill_base + 2k.
  - issue_cnt counts 0..7. mem_req = 0 after 8 issues.
- FILL return:
  - Each mem_rvalid writes mem_rdata into data_arr[index][ret_cnt]; ret_cnt then increments.
  - On the 8th return (cycle T+8+MEM_LAT): write tag, set valid, next state = IDLE.
- Stall window: cpu_stall = 1 throughout FILL, i.e. cycles T .. T+8+MEM_LAT (13 cycles for MEM_LAT=4). The retried access hits at T+9+MEM_LAT with stall=0.
- Store (IDLE, any hit state):
  - mem_req=1, mem_we=1, mem_addr={addr[15:1],1'b0}, mem_wdata=cpu_wdata, same cycle. Memory accepts writes in one cycle. cpu_stall = 0.
  - If hit: data_arr[index][word] <= cpu_wdata at the clock edge.
  - Miss: no allocation.
- cpu_en=0: no memory traffic, cpu_stall=0, cpu_rdata holds last driven value or 0. Don't care to the CPU; the bench ignores it.
- mem_rvalid in IDLE (stale after reset): ignored, never written.
- Reset during FILL: abort immediately. The partially filled line stays invalid; in-flight returns are discarded per the rule above.
- cpu_wr=1 and cpu_en=1 while in FILL: not possible (CPU stalled). Illegal; assertion in the bench.
- Every array write happens at the clock edge. A same-cycle read of a word being written returns the old value.

Decomposition:
- Shared package: address field widths/positions (TAG_W=7, IDX_W=5, OFF_W=3), state encoding (IDLE=1'b0, FILL=1'b1), MEM_LAT default.
- Sub-module dcache_array holds the data, tag and valid arrays:
  - combinational read by index/word;
  - synchronous word write;
  - tag+valid write;
  - synchronous clear of valid on rst.
- The FSM, counters and request muxing stay in dcache_ctrl.

Test Plan:
- Cold load 0x1234 after reset; memory word at 0x1234 = 0xBEEF, 0x1230..0x123E = 0xA000+k → stall high 13 cycles; mem_addr sequence 0x1230..0x123E; then cpu_rdata=0xBEEF, stall=0.
- Load 0x1238 right after the fill → hit, cpu_rdata=0xA004, no mem_req, stall never rises.
- Store 0x5555 to 0x1236 (hit) → mem_req=1, mem_we=1, mem_addr=0x1236, mem_wdata=0x5555 same cycle; following load 0x1236 → 0x5555, no stall.
- Store to 0x4000 (miss) then load 0x4000 → store causes no stall and no allocation; the load misses and fills, returning the stored value from memory.
- Conflict: fill 0x1230, then load 0x3230 (same index 0x03, tag differs) → miss and refill; reload 0x1230 misses again.
- Assert rst at the 4th FILL cycle, with returns still pending → all outputs 0 the next cycle; the stale mem_rvalid pulses are ignored; load 0x1230 afterwards misses and performs a full 13-cycle fill.
